// File: rtl/rr_mon_pkg.sv
// Shared types and helpers for the handshake performance monitor.
package rr_mon_pkg;

  typedef enum logic [1:0] {
    RD_BEATS   = 2'd0,
    RD_LASTS   = 2'd1,
    RD_STALLS  = 2'd2,
    RD_MAXWAIT = 2'd3
  } rd_sel_e;

  localparam int unsigned NUM_SEL = 4;

  // Counters up to 64 bits wide share this one saturating incrementer.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic        inc,
                                          input logic [63:0] max_value);
    logic [63:0] result;
    result = value;
    if (inc && (value != max_value)) begin
      result = value + 64'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_hs_perf_monitor_if.sv
// Tapped handshake channels, control strobes and the shadow read port of the monitor.
interface rr_hs_perf_monitor_if #(
  parameter int CH_CNT    = 5,
  parameter int CNT_WIDTH = 32
);
  localparam int RD_CH_W = $clog2(CH_CNT) + 1;

  logic [CH_CNT-1:0]    ch_valid;
  logic [CH_CNT-1:0]    ch_ready;
  logic [CH_CNT-1:0]    ch_last;
  logic                 clear;
  logic                 snapshot;
  logic                 rd_en;
  logic [RD_CH_W-1:0]   rd_ch;
  logic [1:0]           rd_sel;
  logic                 rd_valid;
  logic [CNT_WIDTH-1:0] rd_data;
  logic [CH_CNT-1:0]    wdog_err;
  logic                 any_err;

  modport master (
    output ch_valid, ch_ready, ch_last, clear, snapshot, rd_en, rd_ch, rd_sel,
    input  rd_valid, rd_data, wdog_err, any_err
  );

  modport slave (
    input  ch_valid, ch_ready, ch_last, clear, snapshot, rd_en, rd_ch, rd_sel,
    output rd_valid, rd_data, wdog_err, any_err
  );

endinterface

// File: rtl/rr_hs_chan_counter.sv
// Live counters, wait-run tracking and watchdog flag for a single tapped channel.
module rr_hs_chan_counter
  import rr_mon_pkg::*;
#(
  parameter int          CNT_WIDTH = 32,
  parameter int unsigned MAX_WAITS = 100000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_valid,
  input  logic                                i_ready,
  input  logic                                i_last,
  input  logic                                i_clear,
  output logic [NUM_SEL-1:0][CNT_WIDTH-1:0]   o_live,
  output logic                                o_wdog
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic w_fire, w_lastf, w_stall, w_wdog_hit;
  logic [CNT_WIDTH-1:0] r_beats, r_lasts, r_stalls, r_run, r_max_wait;
  logic [CNT_WIDTH-1:0] w_beats_base, w_lasts_base, w_stalls_base, w_run_base, w_max_base;
  logic [CNT_WIDTH-1:0] w_beats_next, w_lasts_next, w_stalls_next, w_run_next, w_max_next;
  logic r_wdog;

  assign w_fire  = i_valid & i_ready;
  assign w_lastf = w_fire & i_last;
  assign w_stall = i_valid & ~i_ready;

  // Clear restarts from zero but still folds in this cycle's event.
  assign w_beats_base  = i_clear ? '0 : r_beats;
  assign w_lasts_base  = i_clear ? '0 : r_lasts;
  assign w_stalls_base = i_clear ? '0 : r_stalls;
  assign w_run_base    = i_clear ? '0 : r_run;
  assign w_max_base    = i_clear ? '0 : r_max_wait;

  assign w_beats_next  = CNT_WIDTH'(sat_inc(64'(w_beats_base), w_fire, 64'(CNT_MAX)));
  assign w_lasts_next  = CNT_WIDTH'(sat_inc(64'(w_lasts_base), w_lastf, 64'(CNT_MAX)));
  assign w_stalls_next = CNT_WIDTH'(sat_inc(64'(w_stalls_base), w_stall, 64'(CNT_MAX)));
  assign w_run_next    = w_stall ? CNT_WIDTH'(sat_inc(64'(w_run_base), 1'b1, 64'(CNT_MAX))) : '0;
  assign w_max_next    = (w_stall && (w_run_next > w_max_base)) ? w_run_next : w_max_base;

  assign w_wdog_hit = (MAX_WAITS != 0) && w_stall && (64'(w_run_next) == 64'(MAX_WAITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beats    <= '0;
      r_lasts    <= '0;
      r_stalls   <= '0;
      r_run      <= '0;
      r_max_wait <= '0;
      r_wdog     <= 1'b0;
    end else begin
      r_beats    <= w_beats_next;
      r_lasts    <= w_lasts_next;
      r_stalls   <= w_stalls_next;
      r_run      <= w_run_next;
      r_max_wait <= w_max_next;
      r_wdog     <= (r_wdog & ~i_clear) | w_wdog_hit;
    end
  end

  assign o_live[RD_BEATS]   = r_beats;
  assign o_live[RD_LASTS]   = r_lasts;
  assign o_live[RD_STALLS]  = r_stalls;
  assign o_live[RD_MAXWAIT] = r_max_wait;
  assign o_wdog             = r_wdog;

endmodule

// File: rtl/rr_hs_perf_monitor.sv
// Non-intrusive multi-channel handshake monitor with atomic snapshot and 1-cycle shadow read.
module rr_hs_perf_monitor
  import rr_mon_pkg::*;
#(
  parameter int          CH_CNT    = 5,
  parameter int          CNT_WIDTH = 32,
  parameter int unsigned MAX_WAITS = 100000
) (
  input logic                 clk,
  input logic                 rst,
  rr_hs_perf_monitor_if.slave io_mon
);
  localparam int RD_CH_W = $clog2(CH_CNT) + 1;

  logic [CH_CNT-1:0]    w_wdog;
  logic [CH_CNT-1:0]    w_rd_hit;
  logic [CNT_WIDTH-1:0] w_rd_word [CH_CNT];
  logic [CNT_WIDTH-1:0] w_rd_mux;
  logic [CNT_WIDTH-1:0] r_rd_data;
  logic                 r_rd_valid;
  logic                 r_any_err;
  rd_sel_e              w_rd_sel;

  assign w_rd_sel = rd_sel_e'(io_mon.rd_sel);

  generate
    for (genvar gi = 0; gi < CH_CNT; gi++) begin : g_ch
      logic [NUM_SEL-1:0][CNT_WIDTH-1:0] w_live;
      logic [NUM_SEL-1:0][CNT_WIDTH-1:0] r_shadow;

      rr_hs_chan_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .MAX_WAITS (MAX_WAITS)
      ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_valid (io_mon.ch_valid[gi]),
        .i_ready (io_mon.ch_ready[gi]),
        .i_last  (io_mon.ch_last[gi]),
        .i_clear (io_mon.clear),
        .o_live  (w_live),
        .o_wdog  (w_wdog[gi])
      );

      // Shadow captures register outputs, so a concurrent clear cannot leak in.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_shadow <= '0;
        end else if (io_mon.snapshot) begin
          r_shadow <= w_live;
        end
      end

      assign w_rd_hit[gi]  = (io_mon.rd_ch == RD_CH_W'(gi));
      assign w_rd_word[gi] = r_shadow[w_rd_sel];
    end
  endgenerate

  // Out-of-range channel indices match nothing and read back as zero.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < CH_CNT; i++) begin
      if (w_rd_hit[i]) begin
        w_rd_mux = w_rd_word[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_any_err  <= 1'b0;
    end else begin
      r_rd_valid <= io_mon.rd_en;
      if (io_mon.rd_en) begin
        r_rd_data <= w_rd_mux;
      end
      r_any_err <= |w_wdog;
    end
  end

  assign io_mon.rd_valid = r_rd_valid;
  assign io_mon.rd_data  = r_rd_data;
  assign io_mon.wdog_err = w_wdog;
  assign io_mon.any_err  = r_any_err;

endmodule
